out_ctrl_rr: RTL and testbench

Parametrised N-requester output controller for the pipe datapath.
- Round-robin arbitrates NUM_REQ requesters into a polarity-toggled two-slot ping-pong output buffer.
- The granted requester's word is written into the write slot while the read slot drains to the downstream path when path_rdy is high.
- Generalises the two-requester output controller with configurable width and requester count, per-slot source tagging, and a wrap-around round-robin pointer.

---
 rtl/out_ctrl_rr.sv | 112 +++++++++++
 tb/tb_out_ctrl_rr.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/out_ctrl_rr.sv
// rtl/out_ctrl_rr.sv - round-robin N-requester arbiter into a polarity-toggled two-slot ping-pong output buffer
// Optional requester stall counter enabled by defining OUT_CTRL_STATS_EN.
module out_ctrl_rr #(
  parameter int DATA_W  = 64,
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      polarity,
  input  logic                      path_rdy,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] din,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         dout,
  output logic [IDX_W-1:0]          dout_src,
  output logic                      dout_vld,
  output logic [15:0]               stall_cnt
);

  logic [DATA_W-1:0] slot_data [2];
  logic [IDX_W-1:0]  slot_src [2];
  logic [1:0]        slot_empty;
  logic [IDX_W-1:0]  rr_ptr;

  logic              wslot;
  logic              rslot;
  logic [DATA_W-1:0] din_arr [NUM_REQ];
  logic [IDX_W-1:0]  win_idx;
  logic              win_found;
  logic              grant;
  logic [IDX_W:0]    scan;

  assign wslot = ~polarity;
  assign rslot = polarity;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      din_arr[i] = din[i*DATA_W +: DATA_W];
    end
  end

  // Scan upward from rr_ptr with wrap; the extra bit keeps the sum from aliasing before the modulo.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (scan >= (IDX_W+1)'(NUM_REQ)) begin
        scan = scan - (IDX_W+1)'(NUM_REQ);
      end
      if (!win_found && req[scan[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IDX_W-1:0];
      end
    end
  end

  assign grant = ~rst & slot_empty[wslot] & win_found;

  always_comb begin
    gnt = '0;
    if (grant) begin
      gnt[win_idx] = 1'b1;
    end
  end

  assign dout_vld = path_rdy & ~slot_empty[rslot] & ~rst;
  assign dout     = dout_vld ? slot_data[rslot] : '0;
  assign dout_src = dout_vld ? slot_src[rslot] : '0;

  // Write and drain always hit opposite slots, so both updates can land in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_empty <= 2'b11;
      rr_ptr     <= '0;
    end else begin
      if (grant) begin
        slot_empty[wslot] <= 1'b0;
        rr_ptr            <= (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
      end
      if (dout_vld) begin
        slot_empty[rslot] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      slot_data[wslot] <= din_arr[win_idx];
      slot_src[wslot]  <= win_idx;
    end
  end

`ifdef OUT_CTRL_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 16'h0;
    end else if (|req && !grant && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_out_ctrl_rr.sv
// tb/tb_out_ctrl_rr.sv - directed self-checking bench for out_ctrl_rr
// Stall expectations follow OUT_CTRL_STATS_EN.
module tb_out_ctrl_rr;

  localparam int DATA_W  = 64;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

`ifdef OUT_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                      clk;
  logic                      rst;
  logic                      polarity;
  logic                      path_rdy;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] din;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         dout;
  logic [IDX_W-1:0]          dout_src;
  logic                      dout_vld;
  logic [15:0]               stall_cnt;

  logic [DATA_W-1:0] dw [NUM_REQ];
  logic [3:0]        rr_gnt [5];
  logic [3:0]        rr_vld [5];
  logic [1:0]        rr_src [5];

  int vectors;
  int miscompares;

  out_ctrl_rr #(.DATA_W(DATA_W), .NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .polarity  (polarity),
    .path_rdy  (path_rdy),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .dout      (dout),
    .dout_src  (dout_src),
    .dout_vld  (dout_vld),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    dw[0] = 64'hA5A5_0000_0000_0000;
    dw[1] = 64'h1234_5678_9ABC_DEF1;
    dw[2] = 64'hA5A5_0000_0000_0002;
    dw[3] = 64'hFEDC_BA98_7654_3213;
    din = {dw[3], dw[2], dw[1], dw[0]};
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_vld = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
    rr_src = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};

    rst = 1'b1; polarity = 1'b1; path_rdy = 1'b0; req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_gnt", 64'(gnt), 64'h0);
    chk("reset_vld", 64'(dout_vld), 64'h0);
    chk("reset_dout", dout, 64'h0);
    chk("reset_empty", 64'(dut.slot_empty), 64'h3);
    chk("reset_stall", 64'(stall_cnt), 64'h0);
    next_cycle();

    polarity = 1'b1; path_rdy = 1'b1; req = 4'b0100;
    @(negedge clk);
    chk("single_gnt", 64'(gnt), 64'h4);
    chk("single_vld0", 64'(dout_vld), 64'h0);
    next_cycle();
    polarity = 1'b0; req = 4'b0000;
    @(negedge clk);
    chk("single_vld1", 64'(dout_vld), 64'h1);
    chk("single_dout", dout, 64'hA5A5_0000_0000_0002);
    chk("single_src", 64'(dout_src), 64'h2);
    next_cycle();
    @(negedge clk);
    chk("single_vld2", 64'(dout_vld), 64'h0);
    chk("single_dout2", dout, 64'h0);
    next_cycle();

    rst = 1'b1;
    next_cycle();
    rst = 1'b0; req = 4'b1111; path_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      polarity = (i % 2 == 0);
      @(negedge clk);
      chk($sformatf("rr_gnt%0d", i), 64'(gnt), 64'(rr_gnt[i]));
      chk($sformatf("rr_vld%0d", i), 64'(dout_vld), 64'(rr_vld[i]));
      if (rr_vld[i] != 0) begin
        chk($sformatf("rr_src%0d", i), 64'(dout_src), 64'(rr_src[i]));
        chk($sformatf("rr_dout%0d", i), dout, dw[rr_src[i]]);
      end
      next_cycle();
    end
    polarity = 1'b0; req = 4'b0000;
    @(negedge clk);
    chk("flush_dout", dout, dw[0]);
    chk("flush_src", 64'(dout_src), 64'h0);
    next_cycle();

    path_rdy = 1'b0; req = 4'b0001; polarity = 1'b1;
    @(negedge clk);
    chk("bp_gnt0", 64'(gnt), 64'h1);
    next_cycle();
    polarity = 1'b0;
    @(negedge clk);
    chk("bp_gnt1", 64'(gnt), 64'h1);
    next_cycle();
    polarity = 1'b1;
    @(negedge clk);
    chk("bp_gnt2", 64'(gnt), 64'h0);
    chk("bp_empty", 64'(dut.slot_empty), 64'h0);
    chk("bp_stall0", 64'(stall_cnt), 64'h0);
    next_cycle();
    polarity = 1'b0;
    @(negedge clk);
    chk("bp_gnt3", 64'(gnt), 64'h0);
    chk("bp_stall1", 64'(stall_cnt), STATS ? 64'h1 : 64'h0);
    next_cycle();
    @(negedge clk);
    chk("bp_vld", 64'(dout_vld), 64'h0);
    chk("bp_stall2", 64'(stall_cnt), STATS ? 64'h2 : 64'h0);
    next_cycle();

    rst = 1'b1; path_rdy = 1'b1;
    @(negedge clk);
    chk("rstmid_vld", 64'(dout_vld), 64'h0);
    chk("rstmid_gnt", 64'(gnt), 64'h0);
    next_cycle();
    rst = 1'b0; req = 4'b1000; polarity = 1'b1;
    @(negedge clk);
    chk("rstmid_empty", 64'(dut.slot_empty), 64'h3);
    chk("rstmid_gnt8", 64'(gnt), 64'h8);
    chk("rstmid_vld2", 64'(dout_vld), 64'h0);
    chk("rstmid_stall", 64'(stall_cnt), 64'h0);
    next_cycle();

    polarity = 1'b0; req = 4'b0100;
    @(negedge clk);
    chk("skip_pre_gnt", 64'(gnt), 64'h4);
    chk("skip_pre_dout", dout, dw[3]);
    chk("skip_pre_src", 64'(dout_src), 64'h3);
    next_cycle();
    polarity = 1'b1; req = 4'b0010;
    @(negedge clk);
    chk("skip_gnt", 64'(gnt), 64'h2);
    chk("skip_src", 64'(dout_src), 64'h2);
    next_cycle();
    polarity = 1'b0; req = 4'b1111;
    @(negedge clk);
    chk("skip_ptr_gnt", 64'(gnt), 64'h4);
    chk("skip_dout", dout, dw[1]);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
